opl3_timers: RTL and testbench

OPL3 Timer 1 / Timer 2 block: two 8-bit up-counters that advance on prescaled divisions of the sample-rate enable pulse from the clock divider, set overflow flags, and raise a level interrupt. It sits directly downstream of the sample-rate `clk_en` generator and beside the register file, which supplies presets and control bits. It returns the status byte read at register address 0x00.

---
 rtl/opl3_timers.sv | 125 ++++++++++++
 tb/tb_opl3_timers.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/opl3_timers.sv
// OPL3 Timer 1/Timer 2: prescaled 8-bit up-counters, overflow flags, status byte, level irq.
// Flags register one cycle after the overflowing sample tick; irq drives only when OPL3_TIMER_IRQ_EN is defined.

module opl3_timer_chan #(
   parameter int PRESCALE = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sample_clk_en,
   input  logic [7:0] preset,
   input  logic       st,
   input  logic       mt,
   input  logic       irq_rst,
   output logic       flag
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

   logic          st_q, st_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [7:0]    cnt_q, cnt_d;
   logic          flag_q, flag_d;
   logic          start, tick, ovf;

   always_comb begin
      start   = st & ~st_q;
      tick    = st & ~start & sample_clk_en & (presc_q == PRESC_LAST);
      ovf     = tick & (cnt_q == 8'hFF);
      st_d    = st;
      presc_d = presc_q;
      cnt_d   = cnt_q;
      flag_d  = flag_q;

      // A start edge swallows any coincident sample tick.
      if (start) begin
         cnt_d   = preset;
         presc_d = '0;
      end else if (st && sample_clk_en) begin
         if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            cnt_d   = (cnt_q == 8'hFF) ? preset : cnt_q + 8'd1;
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end

      // An overflow in the same cycle as irq_rst wins so the event is not lost.
      if (ovf && !mt) begin
         flag_d = 1'b1;
      end else if (irq_rst) begin
         flag_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st_q    <= 1'b0;
         presc_q <= '0;
         cnt_q   <= 8'h00;
         flag_q  <= 1'b0;
      end else begin
         st_q    <= st_d;
         presc_q <= presc_d;
         cnt_q   <= cnt_d;
         flag_q  <= flag_d;
      end
   end

   assign flag = flag_q;

endmodule

module opl3_timers #(
   parameter int T1_PRESCALE = 4,
   parameter int T2_PRESCALE = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sample_clk_en,
   input  logic [7:0] timer1_preset,
   input  logic [7:0] timer2_preset,
   input  logic       st1,
   input  logic       st2,
   input  logic       mt1,
   input  logic       mt2,
   input  logic       irq_rst,
   output logic       ft1,
   output logic       ft2,
   output logic       irq,
   output logic [7:0] status
);

   opl3_timer_chan #(.PRESCALE(T1_PRESCALE)) u_timer1 (
      .clk           (clk),
      .reset         (reset),
      .sample_clk_en (sample_clk_en),
      .preset        (timer1_preset),
      .st            (st1),
      .mt            (mt1),
      .irq_rst       (irq_rst),
      .flag          (ft1)
   );

   opl3_timer_chan #(.PRESCALE(T2_PRESCALE)) u_timer2 (
      .clk           (clk),
      .reset         (reset),
      .sample_clk_en (sample_clk_en),
      .preset        (timer2_preset),
      .st            (st2),
      .mt            (mt2),
      .irq_rst       (irq_rst),
      .flag          (ft2)
   );

   assign status = {ft1 | ft2, ft1, ft2, 5'b00000};

`ifdef OPL3_TIMER_IRQ_EN
   assign irq = ft1 | ft2;
`else
   // Software can still poll status[7] when the interrupt line is compiled out.
   assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_opl3_timers.sv
// Bench for opl3_timers: directed scenarios then random traffic, every cycle compared to a remaining-ticks model.
module tb_opl3_timers;

   localparam int P1 = 4;
   localparam int P2 = 16;
`ifdef OPL3_TIMER_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset, sample_clk_en, st1, st2, mt1, mt2, irq_rst;
   logic [7:0] timer1_preset, timer2_preset;
   logic       ft1, ft2, irq;
   logic [7:0] status;

   int chk_cnt = 0;
   int err_cnt = 0;

   // Model: sample ticks left until each timer's next overflow, plus flag state.
   int rem1 = 256 * P1;
   int rem2 = 256 * P2;
   bit pst1 = 1'b0, pst2 = 1'b0;
   bit mf1 = 1'b0, mf2 = 1'b0;

   always #5 clk = ~clk;

   opl3_timers #(.T1_PRESCALE(P1), .T2_PRESCALE(P2)) dut (
      .clk           (clk),
      .reset         (reset),
      .sample_clk_en (sample_clk_en),
      .timer1_preset (timer1_preset),
      .timer2_preset (timer2_preset),
      .st1           (st1),
      .st2           (st2),
      .mt1           (mt1),
      .mt2           (mt2),
      .irq_rst       (irq_rst),
      .ft1           (ft1),
      .ft2           (ft2),
      .irq           (irq),
      .status        (status)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      chk_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tmodel(input bit st, input bit pst, input int rem_in, input logic [7:0] preset,
                         input int p, output int rem_out, output bit ov);
      ov      = 1'b0;
      rem_out = rem_in;
      if (st && !pst) begin
         rem_out = (256 - int'(preset)) * p;
      end else if (st && sample_clk_en) begin
         rem_out = rem_in - 1;
         if (rem_out == 0) begin
            ov      = 1'b1;
            rem_out = (256 - int'(preset)) * p;
         end
      end
   endtask

   task automatic model_edge();
      int r1, r2;
      bit ov1, ov2;
      if (reset) begin
         rem1 = 256 * P1; rem2 = 256 * P2;
         pst1 = 1'b0; pst2 = 1'b0; mf1 = 1'b0; mf2 = 1'b0;
      end else begin
         tmodel(st1, pst1, rem1, timer1_preset, P1, r1, ov1);
         tmodel(st2, pst2, rem2, timer2_preset, P2, r2, ov2);
         rem1 = r1; rem2 = r2;
         pst1 = st1; pst2 = st2;
         if (ov1 && !mt1) mf1 = 1'b1; else if (irq_rst) mf1 = 1'b0;
         if (ov2 && !mt2) mf2 = 1'b1; else if (irq_rst) mf2 = 1'b0;
      end
   endtask

   task automatic cyc();
      logic [7:0] exp_status;
      @(posedge clk);
      model_edge();
      #1;
      exp_status = {mf1 | mf2, mf1, mf2, 5'b00000};
      chk("model_ft1", {7'b0, ft1}, {7'b0, mf1});
      chk("model_ft2", {7'b0, ft2}, {7'b0, mf2});
      chk("model_irq", {7'b0, irq}, {7'b0, IRQ_EN & (mf1 | mf2)});
      chk("model_status", status, exp_status);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         sample_clk_en = 1'b1;
         cyc();
         sample_clk_en = 1'b0;
         cyc();
      end
   endtask

   task automatic pulse_irq_rst();
      irq_rst = 1'b1;
      cyc();
      irq_rst = 1'b0;
   endtask

   initial begin
      reset = 1'b1; sample_clk_en = 1'b0; st1 = 1'b0; st2 = 1'b0;
      mt1 = 1'b0; mt2 = 1'b0; irq_rst = 1'b0;
      timer1_preset = 8'h00; timer2_preset = 8'h00;
      repeat (3) cyc();
      chk("reset_status", status, 8'h00);
      chk("reset_irq", {7'b0, irq}, 8'h00);
      reset = 1'b0;

      // Idle with both timers stopped.
      tick(100);
      chk("idle_status", status, 8'h00);
      chk("idle_irq", {7'b0, irq}, 8'h00);

      // Timer 1, preset 0xFF: one increment per overflow, four sample ticks.
      timer1_preset = 8'hFF; st1 = 1'b1;
      cyc();
      tick(3);
      chk("t1_before_ovf", {7'b0, ft1}, 8'h00);
      tick(1);
      chk("t1_ovf_ft1", {7'b0, ft1}, 8'h01);
      chk("t1_ovf_status", status, 8'hC0);
      chk("t1_ovf_irq", {7'b0, irq}, {7'b0, IRQ_EN});
      pulse_irq_rst();
      chk("t1_clr_status", status, 8'h00);
      st1 = 1'b0;
      cyc();

      // Timer 2 masked, then unmasked.
      timer2_preset = 8'hFE; mt2 = 1'b1; st2 = 1'b1;
      cyc();
      tick(32);
      chk("t2_masked_ft2", {7'b0, ft2}, 8'h00);
      chk("t2_masked_status", status, 8'h00);
      mt2 = 1'b0;
      tick(31);
      chk("t2_before_ovf", {7'b0, ft2}, 8'h00);
      tick(1);
      chk("t2_ovf_ft2", {7'b0, ft2}, 8'h01);
      chk("t2_ovf_status", status, 8'hA0);
      mt2 = 1'b1;
      repeat (3) cyc();
      chk("mask_keeps_flag", {7'b0, ft2}, 8'h01);
      mt2 = 1'b0;

      // Both flags, clear, then clear coincident with a Timer 1 overflow.
      st1 = 1'b1;
      cyc();
      tick(4);
      chk("both_status", status, 8'hE0);
      pulse_irq_rst();
      chk("both_clr_status", status, 8'h00);
      tick(3);
      sample_clk_en = 1'b1; irq_rst = 1'b1;
      cyc();
      sample_clk_en = 1'b0; irq_rst = 1'b0;
      chk("coinc_ft1", {7'b0, ft1}, 8'h01);
      chk("coinc_ft2", {7'b0, ft2}, 8'h00);
      chk("coinc_status", status, 8'hC0);
      pulse_irq_rst();

      // Stop/restart with preset 0x10, then a preset change mid-period.
      st1 = 1'b0;
      cyc();
      timer1_preset = 8'h10; st1 = 1'b1;
      cyc();
      tick(50);
      st1 = 1'b0;
      tick(20);
      chk("frozen_ft1", {7'b0, ft1}, 8'h00);
      st1 = 1'b1;
      cyc();
      tick(500);
      timer1_preset = 8'hFE;
      tick(459);
      chk("restart_before_ovf", {7'b0, ft1}, 8'h00);
      tick(1);
      chk("restart_ovf", {7'b0, ft1}, 8'h01);
      pulse_irq_rst();
      tick(7);
      chk("new_preset_before", {7'b0, ft1}, 8'h00);
      tick(1);
      chk("new_preset_ovf", {7'b0, ft1}, 8'h01);

      // Reset mid-count with ft2 set; st1/st2 held high through reset.
      tick(32);
      chk("pre_reset_ft2", {7'b0, ft2}, 8'h01);
      reset = 1'b1; sample_clk_en = 1'b1;
      cyc();
      chk("reset_mid_status", status, 8'h00);
      chk("reset_mid_ft", {6'b0, ft1, ft2}, 8'h00);
      chk("reset_mid_irq", {7'b0, irq}, 8'h00);
      reset = 1'b0; sample_clk_en = 1'b0; timer1_preset = 8'hFF;
      cyc();
      tick(4);
      chk("post_reset_status", status, 8'hC0);
      chk("post_reset_irq", {7'b0, irq}, {7'b0, IRQ_EN});

      // Random traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         sample_clk_en = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 39) == 0) st1 = ~st1;
         if ($urandom_range(0, 39) == 0) st2 = ~st2;
         if ($urandom_range(0, 59) == 0) mt1 = ~mt1;
         if ($urandom_range(0, 59) == 0) mt2 = ~mt2;
         if ($urandom_range(0, 49) == 0) timer1_preset = 8'($urandom_range(240, 255));
         if ($urandom_range(0, 49) == 0) timer2_preset = 8'($urandom_range(248, 255));
         irq_rst = ($urandom_range(0, 24) == 0);
         reset = ($urandom_range(0, 299) == 0);
         cyc();
      end
      reset = 1'b0; irq_rst = 1'b0; sample_clk_en = 1'b0;
      cyc();

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
